// File: rtl/xpb_digit_accum.sv
// Digit sequencer and guarded accumulator for the registered xpb LUT bank.
// Build option: define XPB_ZERO_SKIP_EN to skip zero digits instead of issuing them.
module xpb_digit_accum #(
    parameter int WORD_BITS  = 1024,
    parameter int DIGIT_BITS = 5,
    parameter int NUM_DIGITS = 8,
    parameter int SEL_BITS   = 3,
    parameter int GUARD_BITS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_in_valid,
    output logic                             o_in_ready,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] i_upper_in,
    output logic [SEL_BITS-1:0]              o_lut_sel,
    output logic [DIGIT_BITS-1:0]            o_lut_digit,
    input  logic [WORD_BITS-1:0]             i_lut_data,
    output logic                             o_out_valid,
    input  logic                             i_out_ready,
    output logic [WORD_BITS+GUARD_BITS-1:0]  o_sum_out
);

    localparam int ACC_BITS = WORD_BITS + GUARD_BITS;
    localparam int OP_BITS  = NUM_DIGITS * DIGIT_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [OP_BITS-1:0]    r_operand;
    logic [SEL_BITS-1:0]   r_idx;
    logic [SEL_BITS-1:0]   r_lut_sel;
    logic [DIGIT_BITS-1:0] r_lut_digit;
    logic                  r_pend;
    logic                  r_pend_d;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [ACC_BITS-1:0]   r_acc;

    logic [SEL_BITS-1:0]   w_issue_idx;
    logic [DIGIT_BITS-1:0] w_digit;
    logic                  w_more;
    logic                  w_start_done;
`ifdef XPB_ZERO_SKIP_EN
    logic                  w_hit;
    logic                  w_nz;
`endif

    // Select the digit to issue this cycle and whether any issue remains after it.
    always_comb begin
        w_issue_idx  = r_idx;
        w_more       = 1'b0;
        w_start_done = 1'b0;
`ifdef XPB_ZERO_SKIP_EN
        w_hit        = 1'b0;
        w_nz         = 1'b0;
        w_start_done = (i_upper_in == {OP_BITS{1'b0}});
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_nz        = (SEL_BITS'(i) >= r_idx) &&
                          (r_operand[DIGIT_BITS*i +: DIGIT_BITS] != {DIGIT_BITS{1'b0}});
            w_more      = w_more | (w_hit & w_nz);
            w_issue_idx = (!w_hit && w_nz) ? SEL_BITS'(i) : w_issue_idx;
            w_hit       = w_hit | w_nz;
        end
`else
        w_more       = (r_idx != SEL_BITS'(NUM_DIGITS - 1));
`endif
        w_digit = r_operand[DIGIT_BITS*w_issue_idx +: DIGIT_BITS];
    end

    // Sequencer FSM; the LUT word for an issue lands two edges later, tracked by r_pend_d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_operand   <= {OP_BITS{1'b0}};
            r_idx       <= {SEL_BITS{1'b0}};
            r_lut_sel   <= {SEL_BITS{1'b0}};
            r_lut_digit <= {DIGIT_BITS{1'b0}};
            r_pend      <= 1'b0;
            r_pend_d    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_acc       <= {ACC_BITS{1'b0}};
        end else begin
            r_pend_d <= r_pend;
            if (r_pend_d) begin
                r_acc <= r_acc + {{GUARD_BITS{1'b0}}, i_lut_data};
            end else begin
                r_acc <= r_acc;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid && r_in_ready) begin
                        r_operand  <= i_upper_in;
                        r_acc      <= {ACC_BITS{1'b0}};
                        r_idx      <= {SEL_BITS{1'b0}};
                        r_in_ready <= 1'b0;
                        r_state    <= w_start_done ? S_DONE : S_ISSUE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    r_lut_sel   <= w_issue_idx;
                    r_lut_digit <= w_digit;
                    r_pend      <= 1'b1;
                    r_idx       <= w_issue_idx + SEL_BITS'(1);
                    r_state     <= w_more ? S_ISSUE : S_DRAIN;
                end
                S_DRAIN: begin
                    r_pend  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    // First DONE edge coincides with the final accumulate.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_lut_sel   = r_lut_sel;
    assign o_lut_digit = r_lut_digit;
    assign o_sum_out   = r_acc;

endmodule
